riscv_idq: RTL and testbench

Parametrised instruction decode queue that replaces the single-register decode stage between the fetch unit and execute. It accepts fetched words over a valid/ready handshake and expands RV32C encodings to their 32-bit RV32IM equivalents. It flags illegal encodings and buffers up to `DEPTH` decoded entries for the downstream stage, with a flush input for redirects.

---
 rtl/riscv_pkg.sv | 110 +++++++++++
 rtl/riscv_cexpand.sv | 143 ++++++++++++++
 rtl/riscv_idq.sv | 113 +++++++++++
 tb/tb_riscv_idq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V types: opcodes, compressed field view, queue entry,
// and helpers that assemble 32-bit encodings and check RV32IM legality.
package riscv_pkg;

  typedef logic [31:0] instr_type;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam instr_type INSTR_ECALL  = 32'h00000073;
  localparam instr_type INSTR_EBREAK = 32'h00100073;

  typedef struct packed {
    logic [2:0] funct3;
    logic       b12;
    logic [4:0] rd_rs1;
    logic [4:0] rs2;
    logic [1:0] op;
  } cinstr_type;

  typedef struct packed {
    logic [31:0] addr;
    instr_type   data;
    logic        rvc;
    logic        illegal;
  } idq_entry_t;

  function automatic instr_type enc_r(
    input logic [6:0] f7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] f3,
    input logic [4:0] rd,
    input logic [6:0] opc
  );
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic instr_type enc_i(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic instr_type enc_s(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [6:0]  opc
  );
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic instr_type enc_b(
    input logic [12:1] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3
  );
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic instr_type enc_u(
    input logic [19:0] imm,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rd, opc};
  endfunction

  function automatic instr_type enc_j(
    input logic [20:1] imm,
    input logic [4:0]  rd
  );
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic is_legal32(input instr_type i);
    logic ok;
    ok = 1'b0;
    case (i[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_MISC_MEM: ok = 1'b1;
      OPC_OP:
        ok = (i[31:25] == 7'h00) || (i[31:25] == 7'h20) ||
             (i[31:25] == 7'h01);
      OPC_SYSTEM:
        ok = (i == INSTR_ECALL) || (i == INSTR_EBREAK);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_cexpand.sv
// RV32C to RV32I expander, purely combinational, built under RISCV_IDQ_RVC_EN.
// Ports: i_cinstr (16b compressed word), o_instr (32b), o_illegal (reserved/unsupported).
module riscv_cexpand
  import riscv_pkg::*;
(
  input  logic [15:0] i_cinstr,
  output instr_type   o_instr,
  output logic        o_illegal
);

  cinstr_type  w_ci;
  logic [15:0] c;
  logic [4:0]  w_rdp;
  logic [4:0]  w_rs1p;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs2;
  logic [4:0]  w_shamt;
  logic [11:0] w_imm6;
  logic [11:0] w_a4spn;
  logic [11:0] w_lw;
  logic [11:0] w_lwsp;
  logic [11:0] w_swsp;
  logic [11:0] w_a16sp;
  logic [19:0] w_lui;
  logic [20:1] w_jimm;
  logic [12:1] w_bimm;

  assign w_ci    = i_cinstr;
  assign c       = i_cinstr;
  assign w_rdp   = {2'b01, c[4:2]};
  assign w_rs1p  = {2'b01, c[9:7]};
  assign w_rd    = w_ci.rd_rs1;
  assign w_rs2   = w_ci.rs2;
  assign w_shamt = c[6:2];

  assign w_imm6  = {{6{c[12]}}, c[12], c[6:2]};
  assign w_a4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign w_lw    = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign w_lwsp  = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign w_swsp  = {4'b0, c[8:7], c[12:9], 2'b00};
  assign w_a16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  assign w_lui   = {{14{c[12]}}, c[12], c[6:2]};
  assign w_jimm  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6],
                    c[7], c[2], c[11], c[5:3]};
  assign w_bimm  = {{4{c[12]}}, c[12], c[6:5], c[2],
                    c[11:10], c[4:3]};

  always_comb begin
    o_instr   = '0;
    o_illegal = 1'b0;
    unique case ({w_ci.op, w_ci.funct3})
      5'b00_000: begin
        o_illegal = (w_a4spn == '0);
        o_instr   = enc_i(w_a4spn, 5'd2, 3'b000, w_rdp, OPC_OP_IMM);
      end
      5'b00_010:
        o_instr = enc_i(w_lw, w_rs1p, 3'b010, w_rdp, OPC_LOAD);
      5'b00_110:
        o_instr = enc_s(w_lw, w_rdp, w_rs1p, 3'b010, OPC_STORE);
      5'b01_000:
        o_instr = enc_i(w_imm6, w_rd, 3'b000, w_rd, OPC_OP_IMM);
      5'b01_001:
        o_instr = enc_j(w_jimm, 5'd1);
      5'b01_010:
        o_instr = enc_i(w_imm6, 5'd0, 3'b000, w_rd, OPC_OP_IMM);
      5'b01_011: begin
        if (w_rd == 5'd2) begin
          o_illegal = (w_a16sp == '0);
          o_instr   = enc_i(w_a16sp, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
        end else begin
          o_illegal = ({c[12], c[6:2]} == 6'd0);
          o_instr   = enc_u(w_lui, w_rd, OPC_LUI);
        end
      end
      5'b01_100: begin
        unique case (c[11:10])
          2'b00: begin
            o_illegal = c[12];
            o_instr   = enc_r(7'h00, w_shamt, w_rs1p, 3'b101,
                              w_rs1p, OPC_OP_IMM);
          end
          2'b01: begin
            o_illegal = c[12];
            o_instr   = enc_r(7'h20, w_shamt, w_rs1p, 3'b101,
                              w_rs1p, OPC_OP_IMM);
          end
          2'b10:
            o_instr = enc_i(w_imm6, w_rs1p, 3'b111, w_rs1p, OPC_OP_IMM);
          default: begin
            // c[12]=1 here is the RV64 SUBW/ADDW space
            o_illegal = c[12];
            unique case (c[6:5])
              2'b00: o_instr = enc_r(7'h20, w_rdp, w_rs1p, 3'b000,
                                     w_rs1p, OPC_OP);
              2'b01: o_instr = enc_r(7'h00, w_rdp, w_rs1p, 3'b100,
                                     w_rs1p, OPC_OP);
              2'b10: o_instr = enc_r(7'h00, w_rdp, w_rs1p, 3'b110,
                                     w_rs1p, OPC_OP);
              default: o_instr = enc_r(7'h00, w_rdp, w_rs1p, 3'b111,
                                       w_rs1p, OPC_OP);
            endcase
          end
        endcase
      end
      5'b01_101:
        o_instr = enc_j(w_jimm, 5'd0);
      5'b01_110:
        o_instr = enc_b(w_bimm, 5'd0, w_rs1p, 3'b000);
      5'b01_111:
        o_instr = enc_b(w_bimm, 5'd0, w_rs1p, 3'b001);
      5'b10_000: begin
        o_illegal = c[12];
        o_instr   = enc_r(7'h00, w_shamt, w_rd, 3'b001, w_rd, OPC_OP_IMM);
      end
      5'b10_010: begin
        o_illegal = (w_rd == 5'd0);
        o_instr   = enc_i(w_lwsp, 5'd2, 3'b010, w_rd, OPC_LOAD);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (w_rs2 == 5'd0) begin
            o_illegal = (w_rd == 5'd0);
            o_instr   = enc_i(12'd0, w_rd, 3'b000, 5'd0, OPC_JALR);
          end else begin
            o_instr = enc_r(7'h00, w_rs2, 5'd0, 3'b000, w_rd, OPC_OP);
          end
        end else if (w_rs2 == 5'd0) begin
          if (w_rd == 5'd0)
            o_instr = INSTR_EBREAK;
          else
            o_instr = enc_i(12'd0, w_rd, 3'b000, 5'd1, OPC_JALR);
        end else begin
          o_instr = enc_r(7'h00, w_rs2, w_rd, 3'b000, w_rd, OPC_OP);
        end
      end
      5'b10_110:
        o_instr = enc_s(w_swsp, w_rs2, 5'd2, 3'b010, OPC_STORE);
      default:
        o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_idq.sv
// Instruction decode queue: fetch words in, expanded/flagged entries out, DEPTH deep.
// Ports: clock/reset(async high)/flush; ifu_* push side; idu_* head side + idu_count.
// Define RISCV_IDQ_RVC_EN to compile in RV32C expansion; otherwise RVC words are illegal.
module riscv_idq
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             ifu_vld,
  output logic             ifu_rdy,
  input  logic [31:0]      ifu_addr,
  input  logic [31:0]      ifu_data,
  output logic             idu_vld,
  input  logic             idu_rdy,
  output logic [31:0]      idu_addr,
  output instr_type        idu_data,
  output logic             idu_rvc,
  output logic             idu_illegal,
  output logic [CNT_W-1:0] idu_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  idq_entry_t       r_mem [DEPTH];

  logic       w_push;
  logic       w_pop;
  logic       w_is_rvc;
  logic       w_rvc_ill;
  instr_type  w_rvc_data;
  idq_entry_t w_entry;
  idq_entry_t w_head;

  assign w_is_rvc = (ifu_data[1:0] != 2'b11);

`ifdef RISCV_IDQ_RVC_EN
  instr_type w_cx_instr;
  logic      w_cx_ill;

  riscv_cexpand u_cexpand (
    .i_cinstr  (ifu_data[15:0]),
    .o_instr   (w_cx_instr),
    .o_illegal (w_cx_ill)
  );

  assign w_rvc_ill  = w_cx_ill;
  assign w_rvc_data = w_cx_ill ? {16'h0, ifu_data[15:0]} : w_cx_instr;
`else
  assign w_rvc_ill  = 1'b1;
  assign w_rvc_data = {16'h0, ifu_data[15:0]};
`endif

  // a 32-bit word is stored raw whether legal or not
  always_comb begin
    w_entry.addr = ifu_addr;
    w_entry.rvc  = w_is_rvc;
    if (w_is_rvc) begin
      w_entry.data    = w_rvc_data;
      w_entry.illegal = w_rvc_ill;
    end else begin
      w_entry.data    = ifu_data;
      w_entry.illegal = !is_legal32(ifu_data);
    end
  end

  // ready depends only on registered occupancy
  assign ifu_rdy = (r_count < CNT_W'(DEPTH));
  assign idu_vld = (r_count != '0);
  assign w_push  = ifu_vld && ifu_rdy;
  assign w_pop   = idu_vld && idu_rdy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !flush)
      r_mem[r_wptr] <= w_entry;
  end

  assign w_head      = r_mem[r_rptr];
  assign idu_addr    = w_head.addr;
  assign idu_data    = w_head.data;
  assign idu_rvc     = w_head.rvc;
  assign idu_illegal = w_head.illegal;
  assign idu_count   = r_count;

endmodule

// File: tb/tb_riscv_idq.sv
// Scoreboard bench for riscv_idq: directed words in, queued expectations
// popped and compared by a monitor whenever the head is consumed.
module tb_riscv_idq;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        ifu_vld = 1'b0;
  logic        ifu_rdy;
  logic [31:0] ifu_addr = '0;
  logic [31:0] ifu_data = '0;
  logic        idu_vld;
  logic        idu_rdy = 1'b0;
  logic [31:0] idu_addr;
  instr_type   idu_data;
  logic        idu_rvc;
  logic        idu_illegal;
  logic [2:0]  idu_count;

  riscv_idq #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .ifu_vld     (ifu_vld),
    .ifu_rdy     (ifu_rdy),
    .ifu_addr    (ifu_addr),
    .ifu_data    (ifu_data),
    .idu_vld     (idu_vld),
    .idu_rdy     (idu_rdy),
    .idu_addr    (idu_addr),
    .idu_data    (idu_data),
    .idu_rvc     (idu_rvc),
    .idu_illegal (idu_illegal),
    .idu_count   (idu_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  idq_entry_t exp_q[$];
  idq_entry_t m_e;

  localparam int NV = 23;
  // {raw word, hand-expanded data, hand illegal flag} for the RVC build
  logic [31:0] v_w  [NV] = '{
    32'h00000085, 32'h0000852E, 32'h00000001, 32'h00000000,
    32'h00B50533, 32'h0000007F, 32'h02B50533, 32'h10B50533,
    32'h00000073, 32'h30200073, 32'h000052FD, 32'h00004002,
    32'h00009005, 32'h000040C0, 32'h00006101, 32'h00008082,
    32'h00009002, 32'h00000040, 32'h0000C406, 32'h00000037,
    32'hABCD852E, 32'h12340000, 32'h0000100F};
  logic [31:0] v_hd [NV] = '{
    32'h00108093, 32'h00B00533, 32'h00000013, 32'h00000000,
    32'h00B50533, 32'h0000007F, 32'h02B50533, 32'h10B50533,
    32'h00000073, 32'h30200073, 32'hFFF00293, 32'h00004002,
    32'h00009005, 32'h0044A403, 32'h00006101, 32'h00008067,
    32'h00100073, 32'h00410413, 32'h00112423, 32'h00000037,
    32'h00B00533, 32'h00000000, 32'h0000100F};
  logic        v_hi [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  function automatic idq_entry_t mk(input logic [31:0] a, input int vi);
    idq_entry_t e;
    e.addr    = a;
    e.rvc     = (v_w[vi][1:0] != 2'b11);
    e.data    = v_hd[vi];
    e.illegal = v_hi[vi];
`ifndef RISCV_IDQ_RVC_EN
    if (e.rvc) begin
      e.data    = {16'h0, v_w[vi][15:0]};
      e.illegal = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic check(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && !flush && idu_vld && idu_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_head: got addr %h data %h, scoreboard empty",
                 idu_addr, idu_data);
      end else begin
        m_e = exp_q.pop_front();
        check("head_entry", {idu_addr, idu_data, idu_rvc, idu_illegal}, m_e);
      end
    end
  end

  // drive one word; returns #1 after the edge that accepted it
  task automatic send(input logic [31:0] a, input int vi);
    int n;
    n = 0;
    ifu_vld  = 1'b1;
    ifu_addr = a;
    ifu_data = v_w[vi];
    @(negedge clock);
    while (!ifu_rdy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ifu_rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got ifu_rdy 0 expected 1 at addr %h", a);
    end else begin
      exp_q.push_back(mk(a, vi));
    end
    @(posedge clock);
    #1;
    ifu_vld = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    @(negedge clock);
    while ((idu_count != 0 || exp_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(nm, {idu_count, 32'(exp_q.size())}, 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    // reset
    #3 reset = 1'b1;
    #1;
    check("rst_vld", idu_vld, 0);
    check("rst_count", idu_count, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ifu_rdy", ifu_rdy, 1);
    @(posedge clock);
    #1;

    // expansion vectors, single-entry latency first
    idu_rdy = 1'b1;
    check("empty_no_bypass", idu_vld, 0);
    send(32'h100, 0);
    check("lat_vld", idu_vld, 1);
    check("lat_count", idu_count, 1);
    for (int i = 1; i < NV; i++)
      send(32'h100 + 32'(4 * i), i);
    wait_empty("drain_vectors");

    // fill to DEPTH, then pop while a push waits
    idu_rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h2000 + 32'(4 * i), i);
    @(negedge clock);
    check("full_rdy", ifu_rdy, 0);
    check("full_count", idu_count, 4);
    @(posedge clock);
    #1 idu_rdy = 1'b1;
    check("full_pop_rdy", ifu_rdy, 0);
    send(32'h2010, 4);
    check("after_full_count", idu_count, 3);
    wait_empty("drain_fill");

    // steady push+pop at count 2 across pointer wrap
    idu_rdy = 1'b0;
    send(32'h3000, 10);
    send(32'h3004, 13);
    idu_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'h3008 + 32'(4 * i), (i * 3) % NV);
      check("steady_count", idu_count, 2);
    end
    wait_empty("drain_steady");

    // flush with count 3 and a concurrent push
    idu_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h4000 + 32'(4 * i), 15 + i);
    ifu_vld  = 1'b1;
    ifu_addr = 32'hDEAD0000;
    ifu_data = v_w[4];
    flush    = 1'b1;
    @(posedge clock);
    #1;
    flush   = 1'b0;
    ifu_vld = 1'b0;
    exp_q.delete();
    check("flush_vld", idu_vld, 0);
    check("flush_count", idu_count, 0);
    check("flush_rdy", ifu_rdy, 1);
    idu_rdy = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    send(32'h4100, 18);
    wait_empty("drain_flush");

    // asynchronous reset between edges
    idu_rdy = 1'b0;
    send(32'h5000, 1);
    send(32'h5004, 2);
    #2 reset = 1'b1;
    #1;
    check("arst_vld", idu_vld, 0);
    check("arst_count", idu_count, 0);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    check("arst_rdy", ifu_rdy, 1);
    idu_rdy = 1'b1;
    send(32'h5100, 0);
    wait_empty("drain_arst");

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
